// File: rtl/ysyx_22050612_lsu_pkg.sv
// Shared LSU definitions: size encodings, FSM states and the per-request beat plan.
// The beat plan positions store bytes across two doubleword lanes and flags straddling accesses.
package ysyx_22050612_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_WAIT0,
        ST_REQ1,
        ST_WAIT1,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [15:0]  mask16;
        logic [127:0] data128;
        logic         split;
    } plan_t;

    function automatic plan_t beat_plan(input logic [2:0]  off,
                                        input logic [1:0]  size,
                                        input logic [63:0] wdata);
        plan_t       p;
        logic [7:0]  m8;
        logic [63:0] bm;
        case (size)
            SZ_B:    m8 = 8'h01;
            SZ_H:    m8 = 8'h03;
            SZ_W:    m8 = 8'h0F;
            default: m8 = 8'hFF;
        endcase
        for (int i = 0; i < 8; i++) begin
            bm[8*i +: 8] = {8{m8[i]}};
        end
        p.mask16  = {8'h00, m8} << off;
        p.data128 = {64'h0, wdata & bm} << {off, 3'b000};
        p.split   = |p.mask16[15:8];
        return p;
    endfunction

endpackage

// File: rtl/ysyx_22050612_lsu_align.sv
// Combinational load extractor: shifts the two-beat read window down by the byte offset,
// truncates to the access size and sign- or zero-extends.
module ysyx_22050612_lsu_align
    import ysyx_22050612_lsu_pkg::*;
(
    input  logic [127:0] i_data,
    input  logic [2:0]   i_off,
    input  logic [1:0]   i_size,
    input  logic         i_unsigned,
    output logic [63:0]  o_result
);

    logic [63:0] w_sh;

    assign w_sh = 64'(i_data >> {i_off, 3'b000});

    always_comb begin
        o_result = w_sh;
        case (i_size)
            SZ_B: o_result = i_unsigned ? {56'h0, w_sh[7:0]}  : {{56{w_sh[7]}},  w_sh[7:0]};
            SZ_H: o_result = i_unsigned ? {48'h0, w_sh[15:0]} : {{48{w_sh[15]}}, w_sh[15:0]};
            SZ_W: o_result = i_unsigned ? {32'h0, w_sh[31:0]} : {{32{w_sh[31]}}, w_sh[31:0]};
            default: o_result = w_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_22050612_lsu.sv
// Load/store unit: one request per handshake, split into one or two aligned 64-bit bus beats.
// Unsplit access completes in 4 cycles and a split one in 6 with an immediate bus; bus stalls hold outputs stable.
module ysyx_22050612_lsu
    import ysyx_22050612_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_rdata
);

    state_t        r_state;
    state_t        w_next;
    logic          r_wen;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [63:0]   r_addr;
    logic [15:0]   r_mask;
    logic [127:0]  r_data;
    logic          r_split;
    logic [63:0]   r_lo;
    logic [63:0]   r_hi;
    plan_t         w_plan;
    logic [63:0]   w_load;
    logic [63:0]   w_base;
    logic          w_beat1;

    assign w_plan  = beat_plan(req_addr[2:0], req_size, req_wdata);
    assign w_base  = {r_addr[63:3], 3'b000};
    assign w_beat1 = (r_state == ST_REQ1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (req_valid)      w_next = ST_REQ0;
            ST_REQ0:  if (mem_req_ready)  w_next = ST_WAIT0;
            ST_WAIT0: if (mem_resp_valid) w_next = r_split ? ST_REQ1 : ST_RESP;
            ST_REQ1:  if (mem_req_ready)  w_next = ST_WAIT1;
            ST_WAIT1: if (mem_resp_valid) w_next = ST_RESP;
            ST_RESP:                      w_next = ST_IDLE;
            default:                      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wen      <= 1'b0;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_mask     <= '0;
            r_data     <= '0;
            r_split    <= 1'b0;
            r_lo       <= '0;
            r_hi       <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && req_valid) begin
                r_wen      <= req_wen;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                // Loads keep mask/data at zero so the bus sees no write strobes.
                r_mask     <= req_wen ? w_plan.mask16  : 16'h0;
                r_data     <= req_wen ? w_plan.data128 : 128'h0;
                r_split    <= w_plan.split;
                r_lo       <= '0;
                r_hi       <= '0;
            end
            if (r_state == ST_WAIT0 && mem_resp_valid) r_lo <= mem_rdata;
            if (r_state == ST_WAIT1 && mem_resp_valid) r_hi <= mem_rdata;
        end
    end

    ysyx_22050612_lsu_align u_align (
        .i_data     ({r_hi, r_lo}),
        .i_off      (r_addr[2:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_result   (w_load)
    );

    always_comb begin
        req_ready     = (r_state == ST_IDLE);
        resp_valid    = (r_state == ST_RESP);
        resp_rdata    = (r_state == ST_RESP && !r_wen) ? w_load : '0;
        mem_req_valid = (r_state == ST_REQ0) || w_beat1;
        mem_addr      = '0;
        mem_wen       = 1'b0;
        mem_wdata     = '0;
        mem_wmask     = '0;
        if (mem_req_valid) begin
            mem_addr  = w_beat1 ? (w_base + 64'd8) : w_base;
            mem_wen   = r_wen;
            mem_wdata = w_beat1 ? r_data[127:64] : r_data[63:0];
            mem_wmask = w_beat1 ? r_mask[15:8]   : r_mask[7:0];
        end
    end

endmodule
